// File: rtl/mems_scan_pkg.sv
// Shared constants, state types and frame packing for the MEMS raster scan sequencer.
package mems_scan_pkg;

    localparam logic [2:0] CMD_WRITE     = 3'b000;
    localparam logic [2:0] CMD_WRITE_UPD = 3'b010;
    localparam logic [2:0] ADDR_X        = 3'b000;
    localparam logic [2:0] ADDR_Y        = 3'b001;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SEND_X = 3'd2,
        ST_SEND_Y = 3'd3,
        ST_DWELL  = 3'd4
    } scan_state_t;

    typedef enum logic [1:0] {
        FI_IDLE    = 2'd0,
        FI_ISSUE   = 2'd1,
        FI_WAIT_HI = 2'd2,
        FI_WAIT_LO = 2'd3
    } issue_state_t;

    function automatic logic [23:0] make_frame(input logic [2:0] cmd,
                                               input logic [2:0] addr,
                                               input logic [15:0] code);
        return {2'b00, cmd, addr, code};
    endfunction

endpackage

// File: rtl/mems_frame_issuer.sv
// Start/busy handshake for one SPI frame; the word is latched on go and held until the frame completes.
module mems_frame_issuer
    import mems_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [23:0] word,
    input  logic        spi_busy,
    output logic        spi_start,
    output logic [23:0] spi_data,
    output logic        done
);

    issue_state_t state_r;
    issue_state_t state_s;
    logic         spi_start_s;
    logic [23:0]  spi_data_s;

    // State and registered SPI-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= FI_IDLE;
            spi_start <= 1'b0;
            spi_data  <= 24'h000000;
        end else begin
            state_r   <= state_s;
            spi_start <= spi_start_s;
            spi_data  <= spi_data_s;
        end
    end

    // Handshake sequencing; done is combinational so the caller sees completion in the same cycle.
    always_comb begin
        state_s     = state_r;
        spi_start_s = 1'b0;
        spi_data_s  = spi_data;
        done        = 1'b0;
        case (state_r)
            FI_IDLE: begin
                if (go) begin
                    spi_data_s = word;
                    state_s    = FI_ISSUE;
                end else begin
                    state_s = FI_IDLE;
                end
            end
            FI_ISSUE: begin
                if (!spi_busy) begin
                    spi_start_s = 1'b1;
                    state_s     = FI_WAIT_HI;
                end else begin
                    state_s = FI_ISSUE;
                end
            end
            FI_WAIT_HI: begin
                if (spi_busy) begin
                    state_s = FI_WAIT_LO;
                end else begin
                    state_s = FI_WAIT_HI;
                end
            end
            FI_WAIT_LO: begin
                if (!spi_busy) begin
                    done    = 1'b1;
                    state_s = FI_IDLE;
                end else begin
                    state_s = FI_WAIT_LO;
                end
            end
            default: state_s = FI_IDLE;
        endcase
    end

endmodule

// File: rtl/mems_scan_seq.sv
// Raster scan sequencer: init frame after reset, then X frame, Y frame and dwell per raster point.
module mems_scan_seq
    import mems_scan_pkg::*;
#(
    parameter int          X_STEPS   = 100,
    parameter int          Y_STEPS   = 10,
    parameter logic [15:0] X_MIN     = 16'h1000,
    parameter logic [15:0] X_STEP    = 16'h0100,
    parameter logic [15:0] Y_MIN     = 16'h2000,
    parameter logic [15:0] Y_STEP    = 16'h0800,
    parameter int          DWELL     = 1000,
    parameter logic [23:0] INIT_WORD = 24'h380001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        spi_busy,
    output logic        spi_start,
    output logic [23:0] spi_data,
    output logic        point_valid,
    output logic        frame_done,
    output logic [6:0]  x_idx,
    output logic [3:0]  y_idx,
    output logic        scan_active
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    scan_state_t     state_r, state_s;
    logic            issued_r, issued_s;
    logic [15:0]     x_code_r, x_code_s;
    logic [15:0]     y_code_r, y_code_s;
    logic [DW_W-1:0] dwell_r, dwell_s;
    logic [6:0]      x_idx_s;
    logic [3:0]      y_idx_s;
    logic            point_valid_s;
    logic            frame_done_s;
    logic            go_s;
    logic [23:0]     word_s;
    logic            done_s;

    mems_frame_issuer u_issuer (
        .clk       (clk),
        .rst       (rst),
        .go        (go_s),
        .word      (word_s),
        .spi_busy  (spi_busy),
        .spi_start (spi_start),
        .spi_data  (spi_data),
        .done      (done_s)
    );

    // Scan state, raster position and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            issued_r    <= 1'b0;
            x_code_r    <= X_MIN;
            y_code_r    <= Y_MIN;
            dwell_r     <= {DW_W{1'b0}};
            x_idx       <= 7'd0;
            y_idx       <= 4'd0;
            point_valid <= 1'b0;
            frame_done  <= 1'b0;
            scan_active <= 1'b0;
        end else begin
            state_r     <= state_s;
            issued_r    <= issued_s;
            x_code_r    <= x_code_s;
            y_code_r    <= y_code_s;
            dwell_r     <= dwell_s;
            x_idx       <= x_idx_s;
            y_idx       <= y_idx_s;
            point_valid <= point_valid_s;
            frame_done  <= frame_done_s;
            scan_active <= (state_s != ST_IDLE);
        end
    end

    // Next-state, frame selection and point advance; issued_r keeps go to one request per frame.
    always_comb begin
        state_s       = state_r;
        x_code_s      = x_code_r;
        y_code_s      = y_code_r;
        dwell_s       = dwell_r;
        x_idx_s       = x_idx;
        y_idx_s       = y_idx;
        point_valid_s = 1'b0;
        frame_done_s  = 1'b0;
        go_s          = 1'b0;
        word_s        = make_frame(CMD_WRITE, ADDR_X, x_code_r);
        case (state_r)
            ST_INIT: begin
                word_s = INIT_WORD;
                go_s   = !issued_r;
                if (done_s) state_s = ST_IDLE;
                else        state_s = ST_INIT;
            end
            ST_IDLE: begin
                if (enable) state_s = ST_SEND_X;
                else        state_s = ST_IDLE;
            end
            ST_SEND_X: begin
                go_s = !issued_r;
                if (done_s) state_s = ST_SEND_Y;
                else        state_s = ST_SEND_X;
            end
            ST_SEND_Y: begin
                word_s = make_frame(CMD_WRITE_UPD, ADDR_Y, y_code_r);
                go_s   = !issued_r;
                if (done_s) begin
                    point_valid_s = 1'b1;
                    dwell_s       = {DW_W{1'b0}};
                    state_s       = ST_DWELL;
                end else begin
                    state_s = ST_SEND_Y;
                end
            end
            ST_DWELL: begin
                if (dwell_r == DW_W'(DWELL - 1)) begin
                    if (x_idx < 7'(X_STEPS - 1)) begin
                        x_idx_s  = x_idx + 7'd1;
                        x_code_s = x_code_r + X_STEP;
                    end else begin
                        x_idx_s  = 7'd0;
                        x_code_s = X_MIN;
                        if (y_idx < 4'(Y_STEPS - 1)) begin
                            y_idx_s  = y_idx + 4'd1;
                            y_code_s = y_code_r + Y_STEP;
                        end else begin
                            y_idx_s      = 4'd0;
                            y_code_s     = Y_MIN;
                            frame_done_s = 1'b1;
                        end
                    end
                    if (enable) state_s = ST_SEND_X;
                    else        state_s = ST_IDLE;
                end else begin
                    dwell_s = dwell_r + DW_W'(1);
                end
            end
            default: state_s = ST_INIT;
        endcase
        if (done_s) issued_s = 1'b0;
        else        issued_s = issued_r | go_s;
    end

endmodule
